// File: rtl/codon_pkg.sv
// Shared nucleotide, amino-acid and codon constants for the translation path.
// Also holds the sequencer state type and the stop-codon test.
package codon_pkg;

    localparam logic [1:0] NT_G = 2'b00;
    localparam logic [1:0] NT_U = 2'b01;
    localparam logic [1:0] NT_A = 2'b10;
    localparam logic [1:0] NT_C = 2'b11;

    // Codes follow first appearance in the U/C/A/G-ordered codon table.
    localparam logic [4:0] AA_PHE   = 5'd0;
    localparam logic [4:0] AA_LEU   = 5'd1;
    localparam logic [4:0] AA_SER   = 5'd2;
    localparam logic [4:0] AA_TYR   = 5'd3;
    localparam logic [4:0] AA_STOP  = 5'd4;
    localparam logic [4:0] AA_CYS   = 5'd5;
    localparam logic [4:0] AA_TRP   = 5'd6;
    localparam logic [4:0] AA_PRO   = 5'd7;
    localparam logic [4:0] AA_HIS   = 5'd8;
    localparam logic [4:0] AA_GLN   = 5'd9;
    localparam logic [4:0] AA_ARG   = 5'd10;
    localparam logic [4:0] AA_ILE   = 5'd11;
    localparam logic [4:0] AA_MET   = 5'd12;
    localparam logic [4:0] AA_THR   = 5'd13;
    localparam logic [4:0] AA_ASN   = 5'd14;
    localparam logic [4:0] AA_LYS   = 5'd15;
    localparam logic [4:0] AA_VAL   = 5'd16;
    localparam logic [4:0] AA_ALA   = 5'd17;
    localparam logic [4:0] AA_ASP   = 5'd18;
    localparam logic [4:0] AA_GLU   = 5'd19;
    localparam logic [4:0] AA_GLY   = 5'd20;
    localparam logic [4:0] AA_TRUNC = 5'd31;

    localparam logic [5:0] CODON_AUG = {NT_A, NT_U, NT_G};
    localparam logic [5:0] CODON_UAA = {NT_U, NT_A, NT_A};
    localparam logic [5:0] CODON_UAG = {NT_U, NT_A, NT_G};
    localparam logic [5:0] CODON_UGA = {NT_U, NT_G, NT_A};

    typedef enum logic {
        SCAN,
        ASM
    } state_e;

    function automatic logic is_stop(input logic [5:0] c);
        return (c == CODON_UAA) || (c == CODON_UAG) || (c == CODON_UGA);
    endfunction

endpackage

// File: rtl/codon_translation_ctrl_if.sv
// Nucleotide-in / amino-acid-out handshake bundle of the translation sequencer.
// slave = the sequencer, master = the source/sink environment.
interface codon_translation_ctrl_if #(
    parameter int CNT_W = 16
);

    logic [1:0]       nt;
    logic             nt_valid;
    logic             nt_last;
    logic             nt_ready;
    logic [4:0]       aa;
    logic             aa_valid;
    logic             aa_ready;
    logic             aa_first;
    logic             aa_last;
    logic             aa_err;
    logic [CNT_W-1:0] protein_cnt;

    modport slave (
        input  nt, nt_valid, nt_last, aa_ready,
        output nt_ready, aa, aa_valid, aa_first, aa_last, aa_err,
        output protein_cnt
    );

    modport master (
        output nt, nt_valid, nt_last, aa_ready,
        input  nt_ready, aa, aa_valid, aa_first, aa_last, aa_err,
        input  protein_cnt
    );

endinterface

// File: rtl/codon_lut.sv
// Combinational standard genetic-code decoder: codon {nt1,nt2,nt3} -> AA code.
// U and C share bit0=1 in the nucleotide encoding, which splits most boxes.
module codon_lut
    import codon_pkg::*;
(
    input  logic [5:0] codon_i,
    output logic [4:0] aa_o
);

    logic py;
    logic [1:0] n3;

    assign py = codon_i[0];
    assign n3 = codon_i[1:0];

    always_comb begin
        aa_o = AA_TRUNC;
        unique case (codon_i[5:2])
            {NT_U, NT_U}: aa_o = py ? AA_PHE : AA_LEU;
            {NT_U, NT_C}: aa_o = AA_SER;
            {NT_U, NT_A}: aa_o = py ? AA_TYR : AA_STOP;
            {NT_U, NT_G}: aa_o = py ? AA_CYS :
                                 (n3 == NT_A) ? AA_STOP : AA_TRP;
            {NT_C, NT_U}: aa_o = AA_LEU;
            {NT_C, NT_C}: aa_o = AA_PRO;
            {NT_C, NT_A}: aa_o = py ? AA_HIS : AA_GLN;
            {NT_C, NT_G}: aa_o = AA_ARG;
            {NT_A, NT_U}: aa_o = (n3 == NT_G) ? AA_MET : AA_ILE;
            {NT_A, NT_C}: aa_o = AA_THR;
            {NT_A, NT_A}: aa_o = py ? AA_ASN : AA_LYS;
            {NT_A, NT_G}: aa_o = py ? AA_SER : AA_ARG;
            {NT_G, NT_U}: aa_o = AA_VAL;
            {NT_G, NT_C}: aa_o = AA_ALA;
            {NT_G, NT_A}: aa_o = py ? AA_ASP : AA_GLU;
            {NT_G, NT_G}: aa_o = AA_GLY;
        endcase
    end

endmodule

// File: rtl/codon_translation_ctrl.sv
// Start-codon scanner and in-frame codon sequencer feeding codon_lut.
// One output register; a new nucleotide is taken only while it is empty.
module codon_translation_ctrl
    import codon_pkg::*;
#(
    parameter int MAX_LEN = 1023,
    parameter int LEN_W   = 10,
    parameter int CNT_W   = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    codon_translation_ctrl_if.slave io
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [5:0]       win_q;
    logic [1:0]       fill_q;
    logic [1:0]       phase_q;
    logic [LEN_W-1:0] len_q;
    logic [4:0]       aa_q;
    logic             aa_valid_q;
    logic             aa_first_q;
    logic             aa_last_q;
    logic             aa_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic       acc;
    logic [5:0] win_d;
    logic [1:0] fill_d;
    logic [4:0] lut_aa;

    assign acc    = io.nt_valid && !aa_valid_q;
    assign win_d  = {win_q[3:0], io.nt};
    assign fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;

    // In ASM the window holds nt1/nt2, so win_d is the full codon.
    codon_lut u_lut (
        .codon_i (win_d),
        .aa_o    (lut_aa)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            win_q      <= '0;
            fill_q     <= '0;
            phase_q    <= '0;
            len_q      <= '0;
            aa_q       <= '0;
            aa_valid_q <= 1'b0;
            aa_first_q <= 1'b0;
            aa_last_q  <= 1'b0;
            aa_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (aa_valid_q && io.aa_ready) begin
                aa_valid_q <= 1'b0;
            end
            if (acc) begin
                unique case (state_q)
                    SCAN: begin
                        if (fill_q >= 2'd2 && win_d == CODON_AUG) begin
                            aa_q       <= AA_MET;
                            aa_valid_q <= 1'b1;
                            aa_first_q <= 1'b1;
                            aa_last_q  <= io.nt_last;
                            aa_err_q   <= io.nt_last;
                            len_q      <= LEN_ONE;
                            phase_q    <= '0;
                            win_q      <= '0;
                            fill_q     <= '0;
                            state_q    <= io.nt_last ? SCAN : ASM;
                        end else if (io.nt_last) begin
                            win_q  <= '0;
                            fill_q <= '0;
                        end else begin
                            win_q  <= win_d;
                            fill_q <= fill_d;
                        end
                    end
                    ASM: begin
                        if (phase_q != 2'd2) begin
                            if (io.nt_last) begin
                                aa_q       <= AA_TRUNC;
                                aa_valid_q <= 1'b1;
                                aa_first_q <= 1'b0;
                                aa_last_q  <= 1'b1;
                                aa_err_q   <= 1'b1;
                                win_q      <= '0;
                                fill_q     <= '0;
                                phase_q    <= '0;
                                state_q    <= SCAN;
                            end else begin
                                win_q   <= win_d;
                                phase_q <= phase_q + 2'd1;
                            end
                        end else begin
                            aa_valid_q <= 1'b1;
                            aa_first_q <= 1'b0;
                            phase_q    <= '0;
                            win_q      <= '0;
                            // A stop wins over both the length limit and nt_last.
                            if (is_stop(win_d)) begin
                                aa_q      <= AA_STOP;
                                aa_last_q <= 1'b1;
                                aa_err_q  <= 1'b0;
                                cnt_q     <= cnt_q + CNT_ONE;
                                fill_q    <= '0;
                                state_q   <= SCAN;
                            end else if (io.nt_last || len_q == LEN_MAX) begin
                                aa_q      <= lut_aa;
                                aa_last_q <= 1'b1;
                                aa_err_q  <= 1'b1;
                                fill_q    <= '0;
                                state_q   <= SCAN;
                            end else begin
                                aa_q      <= lut_aa;
                                aa_last_q <= 1'b0;
                                aa_err_q  <= 1'b0;
                                len_q     <= len_q + LEN_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign io.nt_ready    = !aa_valid_q;
    assign io.aa          = aa_q;
    assign io.aa_valid    = aa_valid_q;
    assign io.aa_first    = aa_first_q;
    assign io.aa_last     = aa_last_q;
    assign io.aa_err      = aa_err_q;
    assign io.protein_cnt = cnt_q;

endmodule

// File: tb/tb_codon_translation_ctrl.sv
// Directed vector bench for codon_translation_ctrl (MAX_LEN=4 build).
// Vectors carry one nucleotide and the output expected after its acceptance.
module tb_codon_translation_ctrl;

    localparam logic [1:0] G = 2'd0;
    localparam logic [1:0] U = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] C = 2'd3;

    localparam logic [4:0] PHE   = 5'b00000;
    localparam logic [4:0] STOP  = 5'b00100;
    localparam logic [4:0] PRO   = 5'b00111;
    localparam logic [4:0] MET   = 5'b01100;
    localparam logic [4:0] ALA   = 5'b10001;
    localparam logic [4:0] GLY   = 5'b10100;
    localparam logic [4:0] TRUNC = 5'b11111;

    typedef struct {
        logic [1:0] nt;
        logic       last;
        logic       ev;
        logic [4:0] aa;
        logic       f;
        logic       l;
        logic       e;
        int         cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   split;
    vec_t tbl[$];

    codon_translation_ctrl_if #(.CNT_W(16)) bus ();

    codon_translation_ctrl #(
        .MAX_LEN (4),
        .LEN_W   (3),
        .CNT_W   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] n, input logic lst,
                                input logic ev, input logic [4:0] a,
                                input logic f, input logic l,
                                input logic e, input int c);
        vec_t v;
        v.nt = n; v.last = lst; v.ev = ev; v.aa = a;
        v.f = f; v.l = l; v.e = e; v.cnt = c;
        return v;
    endfunction

    task automatic s(input logic [1:0] n, input int c);
        tbl.push_back(mk(n, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c));
    endtask

    task automatic sl(input logic [1:0] n, input int c);
        tbl.push_back(mk(n, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, c));
    endtask

    task automatic o(input logic [1:0] n, input logic lst,
                     input logic [4:0] a, input logic f, input logic l,
                     input logic e, input int c);
        tbl.push_back(mk(n, lst, 1'b1, a, f, l, e, c));
    endtask

    task automatic apply(input vec_t v, input string tag);
        int n;
        n = 0;
        while (bus.nt_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/ready"}, 32'(bus.nt_ready), 32'd1);
        bus.nt       = v.nt;
        bus.nt_last  = v.last;
        bus.nt_valid = 1'b1;
        @(posedge clk); #1;
        bus.nt_valid = 1'b0;
        bus.nt_last  = 1'b0;
        chk({tag, "/valid"}, 32'(bus.aa_valid), 32'(v.ev));
        if (v.ev) begin
            chk({tag, "/aa"}, 32'(bus.aa), 32'(v.aa));
            chk({tag, "/first"}, 32'(bus.aa_first), 32'(v.f));
            chk({tag, "/last"}, 32'(bus.aa_last), 32'(v.l));
            chk({tag, "/err"}, 32'(bus.aa_err), 32'(v.e));
        end
        chk({tag, "/cnt"}, 32'(bus.protein_cnt), 32'(v.cnt));
    endtask

    task automatic aug(input int c);
        s(A, c); s(U, c);
        o(G, 1'b0, MET, 1'b1, 1'b0, 1'b0, c);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.nt       = 2'd0;
        bus.nt_valid = 1'b0;
        bus.nt_last  = 1'b0;
        bus.aa_ready = 1'b1;

        // Segment A, protein_cnt starts at 1 after the backpressure run
        s(G, 1); s(A, 1); s(U, 1);
        o(G, 1'b0, MET, 1'b1, 1'b0, 1'b0, 1);
        s(U, 1); s(U, 1); o(U, 1'b0, PHE, 1'b0, 1'b0, 1'b0, 1);
        s(U, 1); s(A, 1); o(A, 1'b0, STOP, 1'b0, 1'b1, 1'b0, 2);
        aug(2);
        s(G, 2); s(C, 2); o(U, 1'b0, ALA, 1'b0, 1'b0, 1'b0, 2);
        s(A, 2); o(U, 1'b1, TRUNC, 1'b0, 1'b1, 1'b1, 2);
        aug(2);
        for (int k = 0; k < 3; k++) begin
            s(G, 2); s(G, 2); o(G, 1'b0, GLY, 1'b0, 1'b0, 1'b0, 2);
        end
        s(G, 2); s(G, 2); o(G, 1'b0, GLY, 1'b0, 1'b1, 1'b1, 2);
        s(G, 2); s(G, 2); s(G, 2);
        s(U, 2); s(A, 2); s(A, 2); s(C, 2); s(C, 2); s(C, 2);
        aug(2);
        s(U, 2); s(G, 2); o(A, 1'b0, STOP, 1'b0, 1'b1, 1'b0, 3);
        s(A, 3); s(U, 3); o(G, 1'b1, MET, 1'b1, 1'b1, 1'b1, 3);
        aug(3);
        for (int k = 0; k < 3; k++) begin
            s(G, 3); s(G, 3); o(G, 1'b0, GLY, 1'b0, 1'b0, 1'b0, 3);
        end
        s(U, 3); s(A, 3); o(G, 1'b0, STOP, 1'b0, 1'b1, 1'b0, 4);
        aug(4);
        s(A, 4); s(U, 4); o(G, 1'b0, MET, 1'b0, 1'b0, 1'b0, 4);
        s(U, 4); s(G, 4); o(A, 1'b0, STOP, 1'b0, 1'b1, 1'b0, 5);
        aug(5);
        s(C, 5); s(C, 5); o(C, 1'b1, PRO, 1'b0, 1'b1, 1'b1, 5);
        aug(5);
        s(U, 5); s(A, 5); o(A, 1'b1, STOP, 1'b0, 1'b1, 1'b0, 6);
        s(A, 6); sl(U, 6); s(G, 6);
        split = tbl.size();
        // Segment B, after the mid-protein reset
        aug(0);
        s(U, 0); s(A, 0); o(G, 1'b0, STOP, 1'b0, 1'b1, 1'b0, 1);

        #12;
        chk("rst/valid", 32'(bus.aa_valid), 32'd0);
        chk("rst/aa", 32'(bus.aa), 32'd0);
        chk("rst/first", 32'(bus.aa_first), 32'd0);
        chk("rst/last", 32'(bus.aa_last), 32'd0);
        chk("rst/err", 32'(bus.aa_err), 32'd0);
        chk("rst/cnt", 32'(bus.protein_cnt), 32'd0);
        chk("rst/ready", 32'(bus.nt_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Sink stalls for 5 cycles while Met is pending
        bus.aa_ready = 1'b0;
        apply(mk(G, 0, 0, 5'd0, 0, 0, 0, 0), "bp0");
        apply(mk(A, 0, 0, 5'd0, 0, 0, 0, 0), "bp1");
        apply(mk(U, 0, 0, 5'd0, 0, 0, 0, 0), "bp2");
        apply(mk(G, 0, 1, MET, 1, 0, 0, 0), "bp3");
        bus.nt       = U;
        bus.nt_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp/ready_low", 32'(bus.nt_ready), 32'd0);
            chk("bp/hold_valid", 32'(bus.aa_valid), 32'd1);
            chk("bp/hold_aa", 32'(bus.aa), 32'(MET));
            chk("bp/hold_first", 32'(bus.aa_first), 32'd1);
        end
        bus.aa_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp/drain", 32'(bus.aa_valid), 32'd0);
        @(posedge clk); #1;
        bus.nt_valid = 1'b0;
        chk("bp/u_taken", 32'(bus.aa_valid), 32'd0);
        apply(mk(U, 0, 0, 5'd0, 0, 0, 0, 0), "bp4");
        apply(mk(U, 0, 1, PHE, 0, 0, 0, 0), "bp5");
        apply(mk(U, 0, 0, 5'd0, 0, 0, 0, 0), "bp6");
        apply(mk(A, 0, 0, 5'd0, 0, 0, 0, 0), "bp7");
        apply(mk(A, 0, 1, STOP, 0, 1, 0, 1), "bp8");

        for (int i = 0; i < split; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset while Met is held in the output register
        bus.aa_ready = 1'b0;
        apply(mk(A, 0, 0, 5'd0, 0, 0, 0, 6), "ar0");
        apply(mk(U, 0, 0, 5'd0, 0, 0, 0, 6), "ar1");
        apply(mk(G, 0, 1, MET, 1, 0, 0, 6), "ar2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar/valid", 32'(bus.aa_valid), 32'd0);
        chk("ar/aa", 32'(bus.aa), 32'd0);
        chk("ar/first", 32'(bus.aa_first), 32'd0);
        chk("ar/cnt", 32'(bus.protein_cnt), 32'd0);
        chk("ar/ready", 32'(bus.nt_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        bus.aa_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = split; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
